// File: rtl/char_text_buffer_if.sv
// Bus between game-state/renderer logic and char_text_buffer.
// master: drives addresses, writes, selection and vsync; slave: the buffer.
interface char_text_buffer_if #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 4,
    parameter int unsigned CODE_W   = 7
) ();
    logic [ROW_BITS+COL_BITS-1:0] char_xy;
    logic [CODE_W-1:0]            code;
    logic                         hl;
    logic                         wr_en;
    logic [ROW_BITS+COL_BITS-1:0] wr_xy;
    logic [CODE_W-1:0]            wr_code;
    logic                         wr_ack;
    logic [ROW_BITS-1:0]          sel_row;
    logic                         sel_en;
    logic                         vsync;
    logic                         init_busy;

    modport master (
        output char_xy, wr_en, wr_xy, wr_code, sel_row, sel_en, vsync,
        input  code, hl, wr_ack, init_busy
    );

    modport slave (
        input  char_xy, wr_en, wr_xy, wr_code, sel_row, sel_en, vsync,
        output code, hl, wr_ack, init_busy
    );
endinterface

// File: rtl/char_text_buffer.sv
// Writable on-screen character buffer with self-clearing init and row highlight.
// Optional highlight blinking on vsync is enabled by defining CHAR_BLINK_EN.
module char_text_buffer #(
    parameter int unsigned      COL_BITS     = 4,
    parameter int unsigned      ROW_BITS     = 4,
    parameter int unsigned      CODE_W       = 7,
    parameter logic [CODE_W-1:0] BLANK_CODE  = 'h20,
    parameter int unsigned      BLINK_FRAMES = 30
) (
    input  logic                pclk,
    input  logic                rst_n,
    char_text_buffer_if.slave   bus
);
    localparam int unsigned AW    = ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     init_cnt;
    logic [CODE_W-1:0] mem [DEPTH];
    logic              we;
    logic [AW-1:0]     waddr;
    logic [CODE_W-1:0] wdata;
    logic              blink_on;

    // One write port shared by the clearing sweep and run-time writes.
    always_comb begin
        we    = 1'b0;
        waddr = init_cnt;
        wdata = BLANK_CODE;
        if (rst_n) begin
            if (state == ST_INIT) begin
                we = 1'b1;
            end else if (bus.wr_en) begin
                we    = 1'b1;
                waddr = bus.wr_xy;
                wdata = bus.wr_code;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            init_cnt      <= '0;
            bus.init_busy <= 1'b1;
            bus.code      <= BLANK_CODE;
            bus.hl        <= 1'b0;
            bus.wr_ack    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    bus.code   <= BLANK_CODE;
                    bus.hl     <= 1'b0;
                    bus.wr_ack <= 1'b0;
                    init_cnt   <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state         <= ST_RUN;
                        bus.init_busy <= 1'b0;
                    end
                end
                default: begin
                    bus.code   <= mem[bus.char_xy];
                    bus.hl     <= bus.sel_en && (bus.char_xy[AW-1:COL_BITS] == bus.sel_row)
                                  && blink_on;
                    bus.wr_ack <= bus.wr_en;
                end
            endcase
        end
    end

`ifdef CHAR_BLINK_EN
    localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

    logic          vs_cur;
    logic          vs_prev;
    logic [FW-1:0] frame_cnt;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vs_cur    <= 1'b0;
            vs_prev   <= 1'b0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            vs_cur  <= bus.vsync;
            vs_prev <= vs_cur;
            if (vs_cur && !vs_prev) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_blink;

    assign blink_on     = 1'b1;
    assign unused_blink = bus.vsync ^ BLINK_FRAMES[0];
`endif

endmodule

// File: tb/tb_char_text_buffer.sv
// Self-checking bench for char_text_buffer: reference memory model plus
// a queue of expected outputs popped one cycle after each stimulus.
module tb_char_text_buffer;
    logic pclk;
    logic rst_n;

    typedef struct packed {
        logic [6:0] code;
        logic       hl;
        logic       ack;
    } exp_t;

    exp_t       q[$];
    logic [6:0] model [256];
    int         checks;
    int         errors;

    char_text_buffer_if #(.ROW_BITS(4), .COL_BITS(4), .CODE_W(7)) bus ();

    char_text_buffer #(.BLINK_FRAMES(2)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.char_xy = '0;
        bus.wr_en   = 1'b0;
        bus.wr_xy   = '0;
        bus.wr_code = '0;
        bus.sel_row = '0;
        bus.sel_en  = 1'b0;
        bus.vsync   = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 7'h20;
    endtask

    task automatic run_init(input string tag);
        int n;
        n = 0;
        rst_n = 1'b1;
        for (int i = 1; i <= 400 && n == 0; i++) begin
            if (i == 10) begin
                bus.wr_en   = 1'b1;
                bus.wr_xy   = 8'h05;
                bus.wr_code = 7'h7f;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            checks++;
            if (bus.wr_ack !== 1'b0 || bus.code !== 7'h20 || bus.hl !== 1'b0) begin
                errors++;
                $display("FAIL %s_init_outputs cycle %0d: wr_ack=%b code=%h hl=%b required 0/20/0",
                         tag, i, bus.wr_ack, bus.code, bus.hl);
            end
            if (bus.init_busy === 1'b0) n = i;
        end
        bus.wr_en = 1'b0;
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL %s_init_length: busy dropped after %0d cycles, required 256", tag, n);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.init_busy !== 1'b1 || bus.code !== 7'h20 || bus.hl !== 1'b0 || bus.wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b code=%h hl=%b ack=%b required 1/20/0/0",
                     bus.init_busy, bus.code, bus.hl, bus.wr_ack);
        end
        model_clear();
        run_init("reset");
        for (int i = 0; i < 256; i++) begin
            bus.char_xy = 8'(i);
            q.push_back('{code: model[i], hl: 1'b0, ack: 1'b0});
            step();
            e = q.pop_front();
            checks++;
            if (bus.code !== e.code || bus.hl !== e.hl || bus.wr_ack !== e.ack) begin
                errors++;
                $display("FAIL blank_read addr %h: code=%h hl=%b ack=%b required %h/%b/%b",
                         i, bus.code, bus.hl, bus.wr_ack, e.code, e.hl, e.ack);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        bus.wr_en   = 1'b1;
        bus.wr_xy   = 8'h00;
        bus.wr_code = 7'h53;
        bus.char_xy = 8'h01;
        q.push_back('{code: model[8'h01], hl: 1'b0, ack: 1'b1});
        model[8'h00] = 7'h53;
        step();
        bus.wr_en   = 1'b0;
        bus.char_xy = 8'h00;
        e = q.pop_front();
        checks++;
        if (bus.wr_ack !== e.ack || bus.code !== e.code) begin
            errors++;
            $display("FAIL write_ack: ack=%b code=%h required %b/%h", bus.wr_ack, bus.code, e.ack, e.code);
        end
        q.push_back('{code: model[8'h00], hl: 1'b0, ack: 1'b0});
        step();
        e = q.pop_front();
        checks++;
        if (bus.wr_ack !== e.ack || bus.code !== e.code) begin
            errors++;
            $display("FAIL write_readback: ack=%b code=%h required %b/%h", bus.wr_ack, bus.code, e.ack, e.code);
        end
    endtask

    task automatic test_same_addr();
        exp_t e;
        bus.char_xy = 8'h61;
        bus.wr_en   = 1'b1;
        bus.wr_xy   = 8'h61;
        bus.wr_code = 7'h75;
        q.push_back('{code: model[8'h61], hl: 1'b0, ack: 1'b1});
        model[8'h61] = 7'h75;
        step();
        bus.wr_en = 1'b0;
        e = q.pop_front();
        checks++;
        if (bus.code !== e.code || bus.wr_ack !== e.ack) begin
            errors++;
            $display("FAIL same_addr_old: code=%h ack=%b required %h/%b", bus.code, bus.wr_ack, e.code, e.ack);
        end
        q.push_back('{code: model[8'h61], hl: 1'b0, ack: 1'b0});
        step();
        e = q.pop_front();
        checks++;
        if (bus.code !== e.code || bus.wr_ack !== e.ack) begin
            errors++;
            $display("FAIL same_addr_new: code=%h ack=%b required %h/%b", bus.code, bus.wr_ack, e.code, e.ack);
        end
    endtask

    task automatic test_highlight();
        exp_t       e;
        logic [7:0] addrs [3];
        logic       sels  [3];
        addrs[0] = 8'h63; sels[0] = 1'b1;
        addrs[1] = 8'h03; sels[1] = 1'b1;
        addrs[2] = 8'h63; sels[2] = 1'b0;
        bus.sel_row = 4'h6;
        for (int i = 0; i < 3; i++) begin
            bus.sel_en  = sels[i];
            bus.char_xy = addrs[i];
            q.push_back('{code: model[addrs[i]],
                          hl: sels[i] && (addrs[i][7:4] == 4'h6), ack: 1'b0});
            step();
            e = q.pop_front();
            checks++;
            if (bus.hl !== e.hl || bus.code !== e.code) begin
                errors++;
                $display("FAIL highlight_%0d addr %h: hl=%b code=%h required %b/%h",
                         i, addrs[i], bus.hl, bus.code, e.hl, e.code);
            end
        end
        bus.sel_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] ra;
        logic [7:0] wa;
        logic [6:0] wd;
        logic       we;
        logic       se;
        logic [3:0] sr;
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            wa = (i % 4 == 0) ? ra : 8'($urandom_range(0, 255));
            wd = 7'($urandom_range(0, 127));
            we = ($urandom_range(0, 3) != 0);
            se = $urandom_range(0, 1) == 1;
            sr = (i % 3 == 0) ? ra[7:4] : 4'($urandom_range(0, 15));
            bus.char_xy = ra;
            bus.wr_en   = we;
            bus.wr_xy   = wa;
            bus.wr_code = wd;
            bus.sel_en  = se;
            bus.sel_row = sr;
            q.push_back('{code: model[ra], hl: se && (ra[7:4] == sr), ack: we});
            if (we) model[wa] = wd;
            step();
            e = q.pop_front();
            checks++;
            if (bus.code !== e.code || bus.hl !== e.hl || bus.wr_ack !== e.ack) begin
                errors++;
                $display("FAIL back_to_back %0d addr %h: code=%h hl=%b ack=%b required %h/%b/%b",
                         i, ra, bus.code, bus.hl, bus.wr_ack, e.code, e.hl, e.ack);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midinit();
        exp_t       e;
        logic [7:0] addrs [3];
        addrs[0] = 8'h00;
        addrs[1] = 8'h61;
        addrs[2] = 8'hff;
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step();
        checks++;
        if (bus.init_busy !== 1'b1) begin
            errors++;
            $display("FAIL midinit_busy: init_busy=%b required 1", bus.init_busy);
        end
        rst_n = 1'b0;
        step();
        model_clear();
        run_init("midinit");
        for (int i = 0; i < 3; i++) begin
            bus.char_xy = addrs[i];
            q.push_back('{code: model[addrs[i]], hl: 1'b0, ack: 1'b0});
            step();
            e = q.pop_front();
            checks++;
            if (bus.code !== e.code) begin
                errors++;
                $display("FAIL reinit_read addr %h: code=%h required %h", addrs[i], bus.code, e.code);
            end
        end
    endtask

`ifdef CHAR_BLINK_EN
    task automatic test_blink();
        logic exp_hl;
        bus.sel_en  = 1'b1;
        bus.sel_row = 4'h6;
        bus.char_xy = 8'h63;
        step();
        step();
        checks++;
        if (bus.hl !== 1'b1) begin
            errors++;
            $display("FAIL blink_start: hl=%b required 1", bus.hl);
        end
        for (int p = 1; p <= 6; p++) begin
            bus.vsync = 1'b1;
            step();
            bus.vsync = 1'b0;
            for (int k = 0; k < 4; k++) step();
            exp_hl = ((p / 2) % 2) == 0;
            checks++;
            if (bus.hl !== exp_hl) begin
                errors++;
                $display("FAIL blink_pulse_%0d: hl=%b required %b", p, bus.hl, exp_hl);
            end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_same_addr();
        test_highlight();
        test_back_to_back();
`ifdef CHAR_BLINK_EN
        test_blink();
`endif
        test_reset_midinit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
